// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive packet controller: FSM states, error codes, PID width.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_DROP,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_PID  = 2'b01;
  localparam logic [1:0] ERR_LINE = 2'b10;
  localparam logic [1:0] ERR_SIZE = 2'b11;

  localparam int PID_W = 4;

endpackage

// File: rtl/rx_byte_fifo.sv
// Show-ahead byte FIFO with synchronous flush; rdata reads 0 when empty.
// Push is refused when full unless a pop happens in the same cycle; pop when empty is ignored.
module rx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? 8'h00 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Packet controller above the byte RCU: checks PID, buffers payload, posts one record per packet.
// Record appears one cycle after rcving falls and is held until pkt_ack; packets arriving meanwhile are counted in miss_cnt.
module usb_rx_pkt_ctrl
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           rcving,
  input  logic                           w_enable,
  input  logic                           r_error,
  input  logic [7:0]                     rcv_data,
  input  logic                           rd_en,
  output logic [7:0]                     rd_data,
  output logic                           rd_empty,
  output logic                           pkt_valid,
  input  logic                           pkt_ack,
  output logic [PID_W-1:0]               pkt_pid,
  output logic [$clog2(MAX_BYTES+1)-1:0] pkt_len,
  output logic                           pkt_err,
  output logic [1:0]                     err_code,
  output logic [3:0]                     miss_cnt
);

  localparam int LW = $clog2(MAX_BYTES + 1);

  state_t           state, state_n;
  logic             rcving_q, rise, fall;
  logic [1:0]       err_n;
  logic [LW-1:0]    len_n;
  logic [PID_W-1:0] pid_n;
  logic             perr_n;
  logic [3:0]       miss_n;
  logic             push, flush, fifo_full;

  assign rise = rcving && !rcving_q;
  assign fall = !rcving && rcving_q;

  rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (rd_en),
    .flush (flush),
    .wdata (rcv_data),
    .rdata (rd_data),
    .empty (rd_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_n = state;
    err_n   = err_code;
    len_n   = pkt_len;
    pid_n   = pkt_pid;
    perr_n  = pkt_err;
    miss_n  = miss_cnt;
    push    = 1'b0;
    flush   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_PID;
          len_n   = '0;
          err_n   = ERR_NONE;
          perr_n  = 1'b0;
        end
      end
      ST_PID: begin
        if (r_error) begin
          err_n   = ERR_LINE;
          flush   = 1'b1;
          state_n = fall ? ST_DONE : ST_DROP;
        end else if (w_enable) begin
          if (rcv_data[7:4] == ~rcv_data[3:0]) begin
            pid_n   = rcv_data[3:0];
            state_n = fall ? ST_DONE : ST_DATA;
          end else begin
            err_n   = ERR_PID;
            flush   = 1'b1;
            state_n = fall ? ST_DONE : ST_DROP;
          end
        end else if (fall) begin
          err_n   = ERR_PID;
          len_n   = '0;
          state_n = ST_DONE;
        end
      end
      ST_DATA: begin
        if (r_error) begin
          err_n   = ERR_LINE;
          flush   = 1'b1;
          state_n = fall ? ST_DONE : ST_DROP;
        end else if (w_enable && ((pkt_len == LW'(MAX_BYTES)) || (fifo_full && !rd_en))) begin
          err_n   = ERR_SIZE;
          flush   = 1'b1;
          state_n = fall ? ST_DONE : ST_DROP;
        end else begin
          if (w_enable) begin
            push  = 1'b1;
            len_n = pkt_len + LW'(1);
          end
          if (fall) state_n = ST_DONE;
        end
      end
      ST_DROP: begin
        if (fall) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (rise && (miss_cnt != 4'hF)) miss_n = miss_cnt + 4'd1;
        if (pkt_ack) begin
          flush   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Error flag is settled on the same edge the record becomes valid.
    if (state_n == ST_DONE) perr_n = (err_n != ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      rcving_q  <= 1'b1;  // a packet already in flight at reset must not look like a new rise
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_NONE;
      pkt_pid   <= '0;
      pkt_len   <= '0;
      miss_cnt  <= '0;
    end else begin
      state     <= state_n;
      rcving_q  <= rcving;
      pkt_valid <= (state_n == ST_DONE);
      pkt_err   <= perr_n;
      err_code  <= err_n;
      pkt_pid   <= pid_n;
      pkt_len   <= len_n;
      miss_cnt  <= miss_n;
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Scoreboard bench for usb_rx_pkt_ctrl: default instance plus a MAX_BYTES=4 instance on shared receiver inputs.
module tb_usb_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       n_rst, rcving, w_enable, r_error;
  logic [7:0] rcv_data;
  logic       rd_en, pkt_ack, rd_en4, pkt_ack4;

  logic [7:0] rd_data, rd_data4;
  logic       rd_empty, pkt_valid, pkt_err, rd_empty4, pkt_valid4, pkt_err4;
  logic [3:0] pkt_pid, pkt_pid4, miss_cnt, miss_cnt4;
  logic [6:0] pkt_len;
  logic [2:0] pkt_len4;
  logic [1:0] err_code, err_code4;

  typedef struct {
    logic [3:0] pid;
    logic       pid_chk;
    logic [6:0] len;
    logic [1:0] err;
  } rec_t;

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  rec_t       rec_q[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  usb_rx_pkt_ctrl dut (
    .clk(clk), .n_rst(n_rst), .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .rcv_data(rcv_data), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .pkt_pid(pkt_pid), .pkt_len(pkt_len),
    .pkt_err(pkt_err), .err_code(err_code), .miss_cnt(miss_cnt)
  );

  usb_rx_pkt_ctrl #(.MAX_BYTES(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .rcv_data(rcv_data), .rd_en(rd_en4), .rd_data(rd_data4), .rd_empty(rd_empty4),
    .pkt_valid(pkt_valid4), .pkt_ack(pkt_ack4), .pkt_pid(pkt_pid4), .pkt_len(pkt_len4),
    .pkt_err(pkt_err4), .err_code(err_code4), .miss_cnt(miss_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Payload scoreboards: every accepted pop is matched against the next expected byte.
  always @(negedge clk) begin
    if (n_rst && rd_en && !rd_empty) begin
      if (exp_q.size() == 0) chk("rd_unexpected", exp_q.size(), 1);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
    if (n_rst && rd_en4 && !rd_empty4) begin
      if (exp4_q.size() == 0) chk("rd4_unexpected", exp4_q.size(), 1);
      else chk("rd4_data", rd_data4, exp4_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [7:0] pid);
    rcving = 1'b1;
    cyc();
    w_enable = 1'b1;
    rcv_data = pid;
    cyc();
    w_enable = 1'b0;
    cyc();
  endtask

  task automatic send(input logic [7:0] b, input bit exp0, input bit exp4, input bit vis);
    w_enable = 1'b1;
    rcv_data = b;
    if (exp0) exp_q.push_back(b);
    if (exp4) exp4_q.push_back(b);
    cyc();
    w_enable = 1'b0;
    if (vis) chk("byte_visible", rd_empty, 0);
    cyc();
  endtask

  task automatic end_pkt();
    rcving = 1'b0;
    cyc();
  endtask

  task automatic expect_rec(input string tag);
    rec_t r;
    int   n = 0;
    while (!pkt_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, pkt_valid, 1);
    if (rec_q.size() == 0) begin
      chk({tag, "_no_expected_rec"}, rec_q.size(), 1);
    end else begin
      r = rec_q.pop_front();
      if (r.pid_chk) chk({tag, "_pid"}, pkt_pid, r.pid);
      chk({tag, "_len"}, pkt_len, r.len);
      chk({tag, "_err_code"}, err_code, r.err);
      chk({tag, "_pkt_err"}, pkt_err, (r.err != 2'b00));
    end
  endtask

  task automatic do_ack(input string tag);
    pkt_ack = 1'b1;
    cyc();
    pkt_ack = 1'b0;
    chk({tag, "_ack_valid"}, pkt_valid, 0);
    chk({tag, "_ack_empty"}, rd_empty, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, pkt_valid, 0);
    chk({tag, "_pkt_err"}, pkt_err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_pid"}, pkt_pid, 0);
    chk({tag, "_len"}, pkt_len, 0);
    chk({tag, "_miss"}, miss_cnt, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_empty"}, rd_empty, 1);
  endtask

  initial begin
    n_rst = 1'b0; rcving = 1'b0; w_enable = 1'b0; r_error = 1'b0; rcv_data = 8'h00;
    rd_en = 1'b0; pkt_ack = 1'b0; rd_en4 = 1'b0; pkt_ack4 = 1'b0;
    cyc(); cyc();
    check_reset_vals("reset");
    n_rst = 1'b1;
    cyc();

    // Good packet, drained as bytes arrive.
    rd_en = 1'b1;
    rec_q.push_back('{pid: 4'h3, pid_chk: 1'b1, len: 7'd3, err: 2'b00});
    start_pkt(8'hC3);
    send(8'h11, 1, 0, 1);
    send(8'h22, 1, 0, 1);
    send(8'h33, 1, 0, 1);
    end_pkt();
    expect_rec("good");
    rd_en = 1'b0;
    do_ack("good");
    chk("good_drained", exp_q.size(), 0);

    // Bad PID: payload is discarded.
    rec_q.push_back('{pid: 4'h0, pid_chk: 1'b0, len: 7'd0, err: 2'b01});
    start_pkt(8'hC4);
    send(8'hAA, 0, 0, 0);
    send(8'hBB, 0, 0, 0);
    chk("badpid_empty", rd_empty, 1);
    end_pkt();
    expect_rec("badpid");
    do_ack("badpid");

    // Line error after two bytes.
    rec_q.push_back('{pid: 4'h1, pid_chk: 1'b1, len: 7'd2, err: 2'b10});
    start_pkt(8'hE1);
    send(8'h01, 0, 0, 1);
    send(8'h02, 0, 0, 1);
    r_error = 1'b1;
    cyc();
    r_error = 1'b0;
    chk("line_flush", rd_empty, 1);
    end_pkt();
    expect_rec("line");
    do_ack("line");

    // FIFO overrun with no reads.
    rec_q.push_back('{pid: 4'h3, pid_chk: 1'b1, len: 7'd8, err: 2'b11});
    start_pkt(8'hC3);
    for (int i = 0; i < 9; i++) send(8'h40 + 8'(i), 0, 0, 0);
    chk("ovr_flush", rd_empty, 1);
    end_pkt();
    expect_rec("overrun");
    do_ack("overrun");

    // Missed packets while a record is pending.
    rec_q.push_back('{pid: 4'hA, pid_chk: 1'b1, len: 7'd1, err: 2'b00});
    start_pkt(8'h5A);
    send(8'h77, 0, 0, 1);
    end_pkt();
    expect_rec("miss_first");
    for (int p = 0; p < 2; p++) begin
      start_pkt(8'hC3);
      send(8'h99, 0, 0, 0);
      end_pkt();
      cyc();
    end
    chk("miss_cnt", miss_cnt, 2);
    chk("miss_hold_valid", pkt_valid, 1);
    chk("miss_hold_pid", pkt_pid, 4'hA);
    chk("miss_hold_len", pkt_len, 1);
    chk("miss_hold_err", err_code, 0);
    do_ack("miss_first");
    rd_en = 1'b1;
    rec_q.push_back('{pid: 4'h6, pid_chk: 1'b1, len: 7'd1, err: 2'b00});
    start_pkt(8'h96);
    send(8'h44, 1, 0, 1);
    end_pkt();
    expect_rec("after_miss");
    rd_en = 1'b0;
    do_ack("after_miss");

    // Clear the MAX_BYTES=4 instance, then run its length-limit case.
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    cyc();
    rd_en4 = 1'b1;
    rec_q.push_back('{pid: 4'h3, pid_chk: 1'b1, len: 7'd5, err: 2'b00});
    start_pkt(8'hC3);
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 0, (i < 4), 0);
    end_pkt();
    chk("max4_valid", pkt_valid4, 1);
    chk("max4_len", pkt_len4, 4);
    chk("max4_err_code", err_code4, 2'b11);
    chk("max4_pkt_err", pkt_err4, 1);
    expect_rec("max64");
    pkt_ack4 = 1'b1;
    do_ack("max64");
    pkt_ack4 = 1'b0;
    rd_en4 = 1'b0;
    chk("max4_after_ack", pkt_valid4, 0);

    // Reset in the middle of DATA; the rest of that packet must be ignored.
    start_pkt(8'hC3);
    send(8'h61, 0, 0, 1);
    send(8'h62, 0, 0, 1);
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    check_reset_vals("midrst");
    send(8'h63, 0, 0, 0);
    send(8'h64, 0, 0, 0);
    end_pkt();
    cyc(); cyc();
    chk("midrst_no_rec", pkt_valid, 0);
    chk("midrst_empty", rd_empty, 1);

    chk("exp_q_left", exp_q.size(), 0);
    chk("exp4_q_left", exp4_q.size(), 0);
    chk("rec_q_left", rec_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
# usb_rx_pkt_ctrl

Packet-level controller above the USB receiver's byte-level RCU. Consumes the receiver's `rcving`/`w_enable`/`r_error`/`rcv_data` stream and validates the PID byte. Buffers payload bytes in a small FIFO for the downstream consumer and reports each packet as a single completion record (PID, length, error code) held until acknowledged.

## Interface

Parameters:
- `MAX_BYTES`, 64: max payload bytes per packet, excluding PID.
- `FIFO_DEPTH`, 8: payload FIFO entries (power of two).

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `n_rst` in 1: synchronous active-low reset.
- `rcving` in 1: receiver busy with a packet.
- `w_enable` in 1: one-cycle strobe, `rcv_data` holds a valid byte.
- `r_error` in 1: receiver line/framing error.
- `rcv_data` in 8: received byte.
- `rd_en` in 1: pop FIFO head.
- `rd_data` out 8: FIFO head (show-ahead); 8'h00 when empty.
- `rd_empty` out 1: FIFO empty.
- `pkt_valid` out 1: completion record valid; held until `pkt_ack`.
- `pkt_ack` in 1: consumer accepts the record.
- `pkt_pid` out 4: PID[3:0] of the completed packet.
- `pkt_len` out $clog2(MAX_BYTES+1): payload bytes accepted.
- `pkt_err` out 1: packet completed with an error.
- `err_code` out 2: 00 none, 01 PID, 10 LINE, 11 SIZE.
- `miss_cnt` out 4: packets ignored while a record was pending; saturates at 15.

## Operation

- States: IDLE, PID, DATA, DROP, DONE.
- `rcving` edges are detected against a registered copy of `rcving`.
- IDLE: on a `rcving` rise, go to PID. Clear `pkt_len`, `err_code`, `pkt_err`.
- PID: on `w_enable`:
  - `rcv_data[7:4] == ~rcv_data[3:0]`: latch `pkt_pid = rcv_data[3:0]`, go to DATA.
  - Otherwise: `err_code` = 01, go to DROP.
  - A `rcving` fall before any byte: `err_code` = 01, `pkt_len` = 0, go directly to DONE.
- DATA:
  - On `w_enable`, push the byte and increment `pkt_len`.
  - Push with FIFO full and no same-cycle pop: `err_code` = 11, go to DROP.
  - Push when `pkt_len == MAX_BYTES`: `err_code` = 11, go to DROP.
  - On a `rcving` fall: go to DONE.
- r_error: in PID or DATA, `r_error` = 1 sets `err_code` = 10 and goes to DROP.
- Priority within one cycle: `r_error` > SIZE/PID check > normal push. The byte is not pushed on an error cycle.
- DROP:
  - FIFO is flushed on entry; further bytes are ignored.
  - `pkt_len` freezes at the bytes accepted before the error.
  - On a `rcving` fall: go to DONE.
- DONE:
  - `pkt_valid` = 1; `pkt_err` = (`err_code` != 00).
  - `pkt_ack` flushes the FIFO (undrained bytes are discarded) and goes to IDLE.
  - A `rcving` rise while in DONE increments `miss_cnt` (saturating). That packet's bytes are ignored.
  - If `rcving` is still high when ack returns to IDLE, that packet stays ignored; IDLE waits for the next rise.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full.
  - `rd_en` when empty is ignored.
  - Reads are allowed in every state.
- `pkt_ack` while `pkt_valid` = 0 is ignored.

## Timing

- Reset values: state IDLE. All of the following are 0: `pkt_valid`, `pkt_err`, `err_code`, `pkt_pid`, `pkt_len`, `miss_cnt`, `rd_data`. `rd_empty` = 1. FIFO pointers are cleared.
- Reset mid-packet: everything returns to the reset values on the next edge. The remainder of the in-flight packet is ignored until the next `rcving` rise.
- Byte visibility: a byte strobed at cycle N appears at `rd_data` with `rd_empty` = 0 at N+1.
- Completion: a `rcving` fall observed at N gives `pkt_valid` = 1 at N+1. All record fields are stable while valid.
- Ack: `pkt_ack` at N gives `pkt_valid` = 0 and `rd_empty` = 1 at N+1.
- DROP flush: entry at N gives `rd_empty` = 1 at N+1.
- All outputs are registered. There is no combinational path from inputs to outputs except `rd_data` and `rd_empty`, which follow registered FIFO state.

## Structure

- Package `usb_rx_pkg` holds:
  - the state enum;
  - the `err_code` localparams `ERR_NONE`, `ERR_PID`, `ERR_LINE`, `ERR_SIZE`;
  - the PID field width.
- Sub-module `rx_byte_fifo` (parameter `DEPTH`; ports `push`, `pop`, `flush`, `wdata`, `rdata`, `empty`, `full`) provides synchronous flush and show-ahead read.
- The controller FSM, length counter and `miss_cnt` live in `usb_rx_pkt_ctrl`.

## Test plan

- **Good packet:** PID 8'hC3 then 3 bytes 11/22/33, drained as they arrive, `rcving` falls → `pkt_valid` = 1, `pkt_pid` = 3, `pkt_len` = 3, `err_code` = 00; reads return 11, 22, 33.
- **Bad PID:** PID 8'hC4 then 2 bytes → DONE with `err_code` = 01, `pkt_len` = 0, FIFO empty.
- **Line error:** PID 8'hE1, 2 bytes, then `r_error` pulse → FIFO empty next cycle; record has `err_code` = 10, `pkt_len` = 2.
- **Overrun and length:**
  - FIFO_DEPTH = 8, no reads, 9 payload bytes → `err_code` = 11, `pkt_len` = 8.
  - Separately, MAX_BYTES = 4 with continuous reads and 5 bytes → `err_code` = 11, `pkt_len` = 4.
- **Missed packet:** withhold `pkt_ack`, send 2 further packets → `miss_cnt` = 2 and the record is unchanged; after ack, the next packet is processed normally.
- **Reset mid-DATA:** `n_rst` low for 1 cycle after 2 bytes → all outputs at reset values, `rd_empty` = 1; the rest of that packet is ignored.
